// File: rtl/bram_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_arbiter_if : master-side request/response and memory-side bus bundle
//                   shared by bram_arbiter and its two requesters.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface bram_arbiter_if;
  logic        iwM0Req;
  logic        iwM0We;
  logic [31:0] iwM0Addr;
  logic [31:0] iwM0WData;
  logic [3:0]  iwM0Wstrb;
  logic        owM0Gnt;
  logic        owM0RValid;
  logic [31:0] owM0RData;

  logic        iwM1Req;
  logic        iwM1We;
  logic [31:0] iwM1Addr;
  logic [31:0] iwM1WData;
  logic [3:0]  iwM1Wstrb;
  logic        owM1Gnt;
  logic        owM1RValid;
  logic [31:0] owM1RData;

  logic [31:0] owReadAddr;
  logic [31:0] owWriteAddr;
  logic [31:0] owWriteData;
  logic [3:0]  owWstrb;
  logic [31:0] iwReadData;

  modport slave (
    input  iwM0Req, iwM0We, iwM0Addr, iwM0WData, iwM0Wstrb,
    input  iwM1Req, iwM1We, iwM1Addr, iwM1WData, iwM1Wstrb,
    input  iwReadData,
    output owM0Gnt, owM0RValid, owM0RData,
    output owM1Gnt, owM1RValid, owM1RData,
    output owReadAddr, owWriteAddr, owWriteData, owWstrb
  );

  modport master (
    output iwM0Req, iwM0We, iwM0Addr, iwM0WData, iwM0Wstrb,
    output iwM1Req, iwM1We, iwM1Addr, iwM1WData, iwM1Wstrb,
    output iwReadData,
    input  owM0Gnt, owM0RValid, owM0RData,
    input  owM1Gnt, owM1RValid, owM1RData,
    input  owReadAddr, owWriteAddr, owWriteData, owWstrb
  );
endinterface
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_arbiter : two-master round-robin arbiter with bounded burst hold in
//                front of a single-port BRAM. BRAM_ARB_PERF_EN adds counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bram_arbiter #(
  parameter int P_MAX_BURST = 4
) (
  input  logic        iwClk,
  input  logic        iwRst,
`ifdef BRAM_ARB_PERF_EN
  output logic [31:0] owGntCnt0,
  output logic [31:0] owGntCnt1,
`endif
  bram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [7:0] BURST_LIM = 8'(P_MAX_BURST - 1);
  localparam logic [7:0] BURST_MAX = 8'(P_MAX_BURST);

  owner_e      owner_q, owner_d;
  logic        last_gnt_q, last_gnt_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_id_q, rd_id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        gnt0, gnt1, gnt_any;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        rvalid0, rvalid1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!iwRst) begin
      case (owner_q)
        OWN_M0: begin
          if (bus.iwM0Req && (!bus.iwM1Req || burst_cnt_q < BURST_LIM)) gnt0 = 1'b1;
          else if (bus.iwM1Req)                                          gnt1 = 1'b1;
        end
        OWN_M1: begin
          if (bus.iwM1Req && (!bus.iwM0Req || burst_cnt_q < BURST_LIM)) gnt1 = 1'b1;
          else if (bus.iwM0Req)                                          gnt0 = 1'b1;
        end
        default: begin
          // Tie goes to whoever did not win last time.
          if (bus.iwM0Req && bus.iwM1Req) begin
            gnt0 = last_gnt_q;
            gnt1 = !last_gnt_q;
          end else begin
            gnt0 = bus.iwM0Req;
            gnt1 = bus.iwM1Req;
          end
        end
      endcase
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? bus.iwM1We    : bus.iwM0We;
  assign sel_addr  = gnt1 ? bus.iwM1Addr  : bus.iwM0Addr;
  assign sel_wdata = gnt1 ? bus.iwM1WData : bus.iwM0WData;
  assign sel_wstrb = gnt1 ? bus.iwM1Wstrb : bus.iwM0Wstrb;

  // A read still in flight when reset arrives must not be reported.
  assign rvalid0 = rd_pend_q && !rd_id_q && !iwRst;
  assign rvalid1 = rd_pend_q &&  rd_id_q && !iwRst;

  always_comb begin
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = 1'b0;
    rd_id_d     = rd_id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (gnt_any) begin
      owner_d    = gnt1 ? OWN_M1 : OWN_M0;
      last_gnt_d = gnt1;
      if (owner_d == owner_q)
        burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? burst_cnt_q : burst_cnt_q + 8'd1;
      else
        burst_cnt_d = 8'd0;
      rd_pend_d = !sel_we;
      rd_id_d   = gnt1;
      addr_d    = sel_addr;
      wdata_d   = sel_wdata;
    end else begin
      owner_d     = OWN_NONE;
      burst_cnt_d = 8'd0;
    end
    if (rvalid0) rdata0_d = bus.iwReadData;
    if (rvalid1) rdata1_d = bus.iwReadData;
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      owner_q     <= OWN_NONE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= 8'd0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
    end else begin
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.owM0Gnt     = gnt0;
  assign bus.owM1Gnt     = gnt1;
  assign bus.owM0RValid  = rvalid0;
  assign bus.owM1RValid  = rvalid1;
  assign bus.owM0RData   = rvalid0 ? bus.iwReadData : rdata0_q;
  assign bus.owM1RData   = rvalid1 ? bus.iwReadData : rdata1_q;
  assign bus.owReadAddr  = gnt_any ? sel_addr  : addr_q;
  assign bus.owWriteAddr = gnt_any ? sel_addr  : addr_q;
  assign bus.owWriteData = gnt_any ? sel_wdata : wdata_q;
  assign bus.owWstrb     = (gnt_any && sel_we) ? sel_wstrb : 4'd0;

`ifdef BRAM_ARB_PERF_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [31:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q + {31'd0, gnt0};
    gnt_cnt1_d = gnt_cnt1_q + {31'd0, gnt1};
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      gnt_cnt0_q <= 32'd0;
      gnt_cnt1_q <= 32'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign owGntCnt0 = gnt_cnt0_q;
  assign owGntCnt1 = gnt_cnt1_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bram_arbiter : self-checking bench for bram_arbiter with a BRAM model,
//                   directed sequences, a vector table and random traffic.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bram_arbiter;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_arbiter_if bus();

`ifdef BRAM_ARB_PERF_EN
  logic [31:0] cnt0, cnt1;
`endif

  bram_arbiter #(.P_MAX_BURST(P)) dut (
    .iwClk    (clk),
    .iwRst    (rst),
`ifdef BRAM_ARB_PERF_EN
    .owGntCnt0(cnt0),
    .owGntCnt1(cnt1),
`endif
    .bus      (bus)
  );

  // BRAM: 1-cycle read latency, byte-strobed write, read sees pre-write data
  logic [31:0] mem [64];
  logic        pl_en  = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'd0;

  always @(posedge clk) begin
    bus.iwReadData <= mem[bus.owReadAddr[7:2]];
    if (pl_en) mem[pl_idx] <= pl_val;
    else
      for (int b = 0; b < 4; b++)
        if (bus.owWstrb[b]) mem[bus.owWriteAddr[7:2]][8*b +: 8] <= bus.owWriteData[8*b +: 8];
  end

  // Reference model state
  logic [31:0] shadow [64];
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_run   = 0;
  bit          m_pend  = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_data  = 32'd0;
  logic [31:0] m_hold [2] = '{32'd0, 32'd0};
  int unsigned m_cnt  [2] = '{0, 0};

  // Values sampled in the most recent cycle
  logic        s_g0, s_g1, s_rv0, s_rv1;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rd0, s_rd1, s_raddr, s_cnt0, s_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit r0; bit r1; bit g0; bit g1; bit rv0; bit rv1;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, check against the model, advance the model.
  task automatic tick();
    int          win;
    logic        we;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    bit          e_rv0, e_rv1;
    @(negedge clk);
    s_g0 = bus.owM0Gnt;  s_g1 = bus.owM1Gnt;
    s_rv0 = bus.owM0RValid; s_rv1 = bus.owM1RValid;
    s_rd0 = bus.owM0RData;  s_rd1 = bus.owM1RData;
    s_wstrb = bus.owWstrb;  s_raddr = bus.owReadAddr;
`ifdef BRAM_ARB_PERF_EN
    s_cnt0 = cnt0; s_cnt1 = cnt1;
`else
    s_cnt0 = 32'd0; s_cnt1 = 32'd0;
`endif
    win = -1;
    if (!rst) begin
      if (bus.iwM0Req && bus.iwM1Req) begin
        if (m_owner >= 0) win = (m_run < P) ? m_owner : 1 - m_owner;
        else              win = 1 - m_last;
      end else if (bus.iwM0Req) win = 0;
      else if (bus.iwM1Req)     win = 1;
    end
    we = (win == 1) ? bus.iwM1We    : bus.iwM0We;
    a  = (win == 1) ? bus.iwM1Addr  : bus.iwM0Addr;
    wd = (win == 1) ? bus.iwM1WData : bus.iwM0WData;
    ws = (win == 1) ? bus.iwM1Wstrb : bus.iwM0Wstrb;
    e_rv0 = m_pend && !rst && (m_id == 0);
    e_rv1 = m_pend && !rst && (m_id == 1);

    chk("gnt0", 32'(s_g0), 32'(win == 0));
    chk("gnt1", 32'(s_g1), 32'(win == 1));
    chk("wstrb", 32'(s_wstrb), (win >= 0 && we) ? 32'(ws) : 32'd0);
    chk("rvalid0", 32'(s_rv0), 32'(e_rv0));
    chk("rvalid1", 32'(s_rv1), 32'(e_rv1));
    chk("rdata0", s_rd0, e_rv0 ? m_data : m_hold[0]);
    chk("rdata1", s_rd1, e_rv1 ? m_data : m_hold[1]);
    if (win >= 0) begin
      chk("raddr", s_raddr, a);
      chk("waddr", bus.owWriteAddr, a);
      if (we) chk("wdata", bus.owWriteData, wd);
    end
`ifdef BRAM_ARB_PERF_EN
    chk("cnt0", s_cnt0, m_cnt[0]);
    chk("cnt1", s_cnt1, m_cnt[1]);
`endif

    if (rst) begin
      m_owner = -1; m_last = 1; m_run = 0; m_pend = 1'b0;
      m_hold = '{32'd0, 32'd0};
      m_cnt  = '{0, 0};
    end else begin
      if (e_rv0) m_hold[0] = m_data;
      if (e_rv1) m_hold[1] = m_data;
      m_pend = 1'b0;
      if (win >= 0) begin
        m_run   = (win == m_owner) ? m_run + 1 : 1;
        m_owner = win;
        m_last  = win;
        m_cnt[win] = m_cnt[win] + 1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) shadow[a[7:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
          m_pend = 1'b1;
          m_id   = win;
          m_data = shadow[a[7:2]];
        end
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle();
    bus.iwM0Req = 1'b0;
    bus.iwM1Req = 1'b0;
  endtask

  task automatic req0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.iwM0Req = 1'b1; bus.iwM0We = we; bus.iwM0Addr = a; bus.iwM0WData = d; bus.iwM0Wstrb = s;
  endtask

  task automatic req1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.iwM1Req = 1'b1; bus.iwM1We = we; bus.iwM1Addr = a; bus.iwM1WData = d; bus.iwM1Wstrb = s;
  endtask

  initial begin
    logic [31:0] v;
    //          r0 r1 g0 g1 rv0 rv1
    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 1, 0};
    tbl[2]  = '{1, 1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 1};
    tbl[6]  = '{1, 1, 0, 1, 0, 1};
    tbl[7]  = '{1, 1, 0, 1, 0, 1};
    tbl[8]  = '{1, 1, 1, 0, 0, 1};
    tbl[9]  = '{1, 1, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 1};

    idle();
    req0(1'b0, 32'h0, 32'h0, 4'h0); bus.iwM0Req = 1'b0;
    req1(1'b0, 32'h0, 32'h0, 4'h0); bus.iwM1Req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      v = (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'h0 : $urandom;
      pl_en = 1'b1; pl_idx = 6'(i); pl_val = v; shadow[i] = v;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset with both requesting, then M0 wins the first tie
    req0(1'b0, 32'h14, 32'h0, 4'hF);
    req1(1'b1, 32'h18, 32'h1234, 4'hF);
    tick();
    tick();
    chk("rst_gnt0", 32'(s_g0), 32'd0);
    chk("rst_gnt1", 32'(s_g1), 32'd0);
    chk("rst_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_rvalid0", 32'(s_rv0), 32'd0);
    chk("rst_rvalid1", 32'(s_rv1), 32'd0);
    chk("rst_raddr", s_raddr, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_tie_gnt0", 32'(s_g0), 32'd1);
    chk("first_tie_gnt1", 32'(s_g1), 32'd0);
    idle();
    tick();

    // Single master read
    req1(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("single_gnt1", 32'(s_g1), 32'd1);
    idle();
    tick();
    chk("single_rvalid1", 32'(s_rv1), 32'd1);
    chk("single_rdata1", s_rd1, 32'hDEADBEEF);
    chk("single_rvalid0", 32'(s_rv0), 32'd0);

    // Write strobes then read back
    req0(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    tick();
    chk("wr_wstrb", 32'(s_wstrb), 32'h5);
    idle();
    tick();
    chk("wr_wstrb_after", 32'(s_wstrb), 32'h0);
    req0(1'b0, 32'h20, 32'h0, 4'hF);
    tick();
    idle();
    tick();
    chk("wr_readback_rv", 32'(s_rv0), 32'd1);
    chk("wr_readback", s_rd0, 32'h00BB00DD);

    // Contention burst table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.iwM0Req = tbl[i].r0; bus.iwM0We = 1'b0; bus.iwM0Addr = 32'h20 + 32'(4 * i);
      bus.iwM1Req = tbl[i].r1; bus.iwM1We = 1'b0; bus.iwM1Addr = 32'h80 + 32'(4 * i);
      tick();
      chk($sformatf("tbl%0d_gnt0", i), 32'(s_g0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(s_g1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_rv0", i), 32'(s_rv0), 32'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rv1", i), 32'(s_rv1), 32'(tbl[i].rv1));
    end
    idle();

    // Reset in the cycle after an accepted read
    req0(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("midrst_gnt0", 32'(s_g0), 32'd1);
    idle();
    rst = 1'b1;
    tick();
    chk("midrst_rvalid0", 32'(s_rv0), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_rvalid0_after", 32'(s_rv0), 32'd0);
    req0(1'b0, 32'h4, 32'h0, 4'h0);
    req1(1'b0, 32'h8, 32'h0, 4'h0);
    tick();
    chk("midrst_tie_gnt0", 32'(s_g0), 32'd1);
    idle();
    tick();

`ifdef BRAM_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 5) req0(1'b1, 32'(4 * i), $urandom, 4'h0);
      else       req1(1'b0, 32'(4 * i), 32'h0, 4'h0);
      tick();
    end
    idle();
    tick();
    chk("perf_cnt0", s_cnt0, 32'd5);
    chk("perf_cnt1", s_cnt1, 32'd3);
    do_reset();
    tick();
    chk("perf_cnt0_rst", s_cnt0, 32'd0);
    chk("perf_cnt1_rst", s_cnt1, 32'd0);
`endif

    // Random traffic; a pending request holds its fields until granted
    for (int n = 0; n < 3000; n++) begin
      if (!(bus.iwM0Req && !s_g0)) begin
        bus.iwM0Req   = ($urandom_range(0, 99) < 70);
        bus.iwM0We    = ($urandom_range(0, 2) == 0);
        bus.iwM0Addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        bus.iwM0WData = $urandom;
        bus.iwM0Wstrb = 4'($urandom_range(0, 15));
      end
      if (!(bus.iwM1Req && !s_g1)) begin
        bus.iwM1Req   = ($urandom_range(0, 99) < 70);
        bus.iwM1We    = ($urandom_range(0, 2) == 0);
        bus.iwM1Addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        bus.iwM1WData = $urandom;
        bus.iwM1Wstrb = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Two-master arbiter that shares the single bram_memory port between the ice_risc_rv core (master 0) and a second requester (master 1: debug loader / DMA). It sits between the masters and bram_memory, drives the memory's split read/write address, write data and byte-strobe inputs, and routes the 1-cycle-latency read data back to whichever master issued the read. Arbitration is round-robin with a bounded burst hold, so one master can stream up to P_MAX_BURST back-to-back accesses before it must yield.

Parameters:
P_MAX_BURST, 4, max consecutive grants to one master while the other is requesting; legal 1..255.

Ports:
iwClk  in  1  system clock; single clock domain.
iwRst  in  1  reset, synchronous, active-high.
iwM0Req  in  1  master 0 request; held with its fields until granted.
iwM0We  in  1  master 0: 1 = write, 0 = read.
iwM0Addr  in  32  master 0 byte address.
iwM0WData  in  32  master 0 write data.
iwM0Wstrb  in  4  master 0 byte strobes; ignored for reads.
owM0Gnt  out  1  master 0 access accepted this cycle.
owM0RValid  out  1  master 0 read data valid.
owM0RData  out  32  master 0 read data.
iwM1Req, iwM1We, iwM1Addr, iwM1WData, iwM1Wstrb, owM1Gnt, owM1RValid, owM1RData: same widths and meaning for master 1.
owReadAddr  out  32  to bram_memory read address.
owWriteAddr  out  32  to bram_memory write address.
owWriteData  out  32  to bram_memory write data.
owWstrb  out  4  to bram_memory byte strobes; 0 = no write.
iwReadData  in  32  from bram_memory; valid 1 cycle after the read address.

Behaviour:
- Reset values: rOwner = NONE, rLastGnt = 1 (so master 0 wins the first tie), rBurstCnt = 0, rRdPend = 0. All owMxGnt/owMxRValid = 0, owWstrb = 0, addresses/data/RData = 0.
- State: rOwner in {NONE, M0, M1}; 8-bit rBurstCnt, saturating at P_MAX_BURST.
- Grant decision is combinational, from registered state plus the current requests, and is made in the same cycle the request is seen:
  - If rOwner = Mx and Mx requests, Mx keeps the grant when the other master is idle or rBurstCnt < P_MAX_BURST-1. Otherwise the grant passes to the other master.
  - If the owner is not requesting, a single requester wins.
  - If rOwner = NONE and both masters request, the master != rLastGnt wins.
  - At most one owMxGnt is high per cycle. An accepted transaction is Req&&Gnt.
- Next state, on the clock edge:
  - Granted master becomes rOwner and rLastGnt.
  - rBurstCnt: 0 on an owner change, +1 (saturating) on a repeat grant.
  - No grant: rOwner = NONE, rBurstCnt = 0, rLastGnt held.
- Memory drive on a granted cycle:
  - owReadAddr and owWriteAddr both get the granted Addr.
  - owWriteData gets the granted WData.
  - owWstrb gets the granted Wstrb if We=1, else 0.
- Memory drive with no grant: owWstrb = 0; addresses and data hold their last values.
- Read return: an accepted read sets rRdPend and rRdId for one cycle.
  - The next cycle, owMxRValid for rRdId = 1 and owMxRData = iwReadData. The other master's RValid = 0 and its RData holds.
  - Back-to-back reads, including reads alternating between masters, return one per cycle in order.
- Writes complete on acceptance; there is no response. A write with Wstrb = 0 is accepted and leaves memory unchanged.
- Read after write to the same address in consecutive cycles returns whatever bram_memory returns; the arbiter adds no forwarding.
- P_MAX_BURST = 1 gives strict alternation under contention.
- Reset asserted mid-operation:
  - The pending read's RValid is suppressed in the following cycle.
  - No grant is issued while iwRst = 1.

Optional Feature:
BRAM_ARB_PERF_EN
- Defined: adds owGntCnt0 and owGntCnt1 (out, 32 bits each). Each counts accepted transactions for its master, increments on the acceptance cycle, wraps at 2^32, and is cleared by iwRst.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset: hold iwRst 2 cycles with both Req=1 -> Gnt=0, owWstrb=0, RValid=0. First cycle after release -> owM0Gnt=1 (M0 wins the tie).
- Single master read: M1 reads addr 0x10 with memory word 0xDEADBEEF, M0 idle -> owM1Gnt the same cycle, owM1RValid=1 with owM1RData=0xDEADBEEF exactly 1 cycle later, owM0RValid=0.
- Contention burst: both masters request reads continuously, P_MAX_BURST=4 -> grant pattern M0,M0,M0,M0,M1,M1,M1,M1,M0..., and each RValid lands on the issuing master.
- Write strobes: M0 writes 0xAABBCCDD with Wstrb=4'b0101 to a word holding 0 -> owWstrb=4'b0101 for that cycle only; a later read returns 0x00BB00DD.
- Reset mid-read: assert iwRst in the cycle after an accepted M0 read -> owM0RValid stays 0 and rOwner=NONE afterwards.
- PERF (macro defined): 5 M0 accesses and 3 M1 accesses -> owGntCnt0=5, owGntCnt1=3; both read 0 after iwRst.
